rob_tag_ctrl: RTL and testbench
===============================

// Module: rob_tag_ctrl
// PURPOSE
//  Reorder-buffer tag controller: producer side of the register-status-table protocol.
//  Allocates 5-bit ROB tags in order at dispatch; the tag feeds the RST write data (Wdata_rst).
//  Marks entries done from the CDB and retires them in program order, one per cycle.
//  At retirement it broadcasts {RB_valid_rst, RB_tag_rst} to the RST and drives the architectural register-file write.
// PARAMETERS
//  DEPTH   32  ROB entries; must equal 2**TAG_W
//  TAG_W   5   tag width; matches RST tag field
//  DATA_W  32  result width
//  AREG_W  5   architectural register address width
// PORTS
//  clock          in   1       single clock, rising edge
//  reset          in   1       asynchronous, active-high
//  flush          in   1       synchronous squash of all entries
//  disp_req       in   1       dispatch requests a tag
//  disp_has_rd    in   1       instruction writes a destination register
//  disp_rd        in   AREG_W  destination register address
//  disp_gnt       out  1       disp_req & ~full & ~flush (combinational)
//  disp_tag       out  TAG_W   tail pointer = tag granted this cycle (to Wdata_rst)
//  cdb_valid      in   1       CDB broadcast valid
//  cdb_tag        in   TAG_W   completing tag
//  cdb_data       in   DATA_W  result
//  RB_valid_rst   out  1       retire pulse to RST (registered)
//  RB_tag_rst     out  TAG_W   retiring tag (registered)
//  commit_wen     out  1       register-file write enable (registered)
//  commit_rd      out  AREG_W  register-file address (registered)
//  commit_data    out  DATA_W  register-file data (registered)
//  full           out  1       count == DEPTH
//  empty          out  1       count == 0
//  count          out  TAG_W+1 occupied entries
// BEHAVIOUR
//  Per entry: busy, done, has_rd, rd, data. State: head, tail (TAG_W, wrap modulo DEPTH), count.
//  Reset: all busy/done = 0; head = tail = 0; count = 0; all registered outputs = 0; empty = 1.
//  Allocate on edge when disp_gnt: entry[tail] <= {busy=1, done=0, has_rd, rd}; tail+1.
//  Complete on edge when cdb_valid & busy[cdb_tag] & ~done[cdb_tag]: done = 1, data = cdb_data.
//   - CDB to a non-busy or already-done tag is ignored; no state change.
//  Retire on edge when busy[head] & done[head]:
//   - busy[head] <= 0; head+1.
//   - RB_valid_rst, commit_wen <= has_rd[head]; RB_tag_rst <= head; commit_rd, commit_data <= entry fields.
//   - No retire that edge: RB_valid_rst and commit_wen <= 0 (one-cycle pulses); other outputs hold.
//  Latency: CDB in cycle N, done at end of N, retire decision end of N+1, pulse visible in N+2.
//  A dispatch and a retire in the same edge both occur; count unchanged.
//  full is evaluated on current count: when full, disp_gnt = 0 even if a retire happens that edge.
//  Allocation and completion on the same tag in one edge: the tag is not busy yet, so the CDB is ignored.
//  Retire of a no-rd entry advances head silently: RB_valid_rst = 0, commit_wen = 0.
//  flush (priority over all else): at edge, all busy/done = 0; head = tail = count = 0;
//   registered outputs = 0; disp_gnt forced 0 in the flush cycle.
//  The RST clears its entry when RB_valid_rst/RB_tag_rst matches its stored {1, tag}.
//   The decoder drives Wen_rst = disp_gnt & disp_has_rd.
//  Reset asserted mid-operation: immediate return to reset state; no pulse issued.
// STRUCTURE
//  rob_defs.vh: TAG_W, DEPTH, DATA_W, AREG_W constants and entry-field bit offsets.
//  Shared by rst, reservation stations and this block.
//  One sub-module, rob_ptr_ctrl: head/tail/count registers and full/empty/gnt logic.
//  Entry storage and the CDB/retire update stay in the top level.
// TESTING
//  1 Reset, then dispatch rd=3 -> disp_tag=0, gnt=1; next dispatch rd=7 -> tag=1, count=2.
//  2 CDB tag 1 data 0xBEEF before tag 0 -> no retire; CDB tag 0 data 0x1234 in cycle N
//    -> N+2: RB_valid_rst=1, tag 0, rd 3, 0x1234; N+3: tag 1, rd 7, 0xBEEF.
//  3 Issue 32 dispatches -> full=1, 33rd gnt=0; retire tag 0 with simultaneous req -> gnt still 0 that cycle,
//    granted next cycle with disp_tag=0 (wrap).
//  4 Dispatch disp_has_rd=0, complete it -> head advances, RB_valid_rst=0, commit_wen=0.
//  5 Five busy entries, flush -> count=0, empty=1; CDB to old tag 2 ignored; next disp_tag=0.
//  6 Reset mid-run with 4 done entries -> all outputs 0 immediately, no RB_valid_rst pulse after release.

Source files
------------

// File: rtl/rob_tag_ctrl_pkg.sv
// rob_tag_ctrl_pkg: shared ROB sizing constants and entry payload layout
package rob_tag_ctrl_pkg;
  localparam int TAG_W  = 5;
  localparam int DEPTH  = 32;
  localparam int DATA_W = 32;
  localparam int AREG_W = 5;
  typedef struct packed {
    logic              has_rd;
    logic [AREG_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } rob_entry_t;
endpackage

// File: rtl/rob_ptr_ctrl.sv
// rob_ptr_ctrl: ROB head/tail/count registers with full/empty and dispatch grant
module rob_ptr_ctrl
  import rob_tag_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             disp_req,
  input  logic             retire,
  output logic [TAG_W-1:0] head,
  output logic [TAG_W-1:0] tail,
  output logic [TAG_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             disp_gnt
);
  assign full = count == (TAG_W+1)'(DEPTH);
  assign empty = count == '0;
  // full is judged on the current count, so a same-edge retire cannot free a slot early
  assign disp_gnt = disp_req & ~full & ~flush;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (disp_gnt) tail <= tail + 1'b1;
      if (retire) head <= head + 1'b1;
      count <= count + {{TAG_W{1'b0}}, disp_gnt} - {{TAG_W{1'b0}}, retire};
    end
endmodule

// File: rtl/rob_tag_ctrl.sv
// rob_tag_ctrl: in-order ROB tag allocation, CDB completion and program-order retirement
module rob_tag_ctrl
  import rob_tag_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              disp_req,
  input  logic              disp_has_rd,
  input  logic [AREG_W-1:0] disp_rd,
  output logic              disp_gnt,
  output logic [TAG_W-1:0]  disp_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              RB_valid_rst,
  output logic [TAG_W-1:0]  RB_tag_rst,
  output logic              commit_wen,
  output logic [AREG_W-1:0] commit_rd,
  output logic [DATA_W-1:0] commit_data,
  output logic              full,
  output logic              empty,
  output logic [TAG_W:0]    count
);
  logic [DEPTH-1:0] busy, done;
  rob_entry_t ent [DEPTH];
  logic [TAG_W-1:0] head;
  logic retire, complete;
  assign retire = busy[head] & done[head];
  assign complete = cdb_valid & busy[cdb_tag] & ~done[cdb_tag];
  rob_ptr_ctrl u_ptr (
    .clock(clock), .reset(reset), .flush(flush), .disp_req(disp_req), .retire(retire),
    .head(head), .tail(disp_tag), .count(count), .full(full), .empty(empty), .disp_gnt(disp_gnt)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      busy <= '0;
      done <= '0;
    end else if (flush) begin
      busy <= '0;
      done <= '0;
    end else begin
      if (disp_gnt) begin
        busy[disp_tag] <= 1'b1;
        done[disp_tag] <= 1'b0;
      end
      if (complete) done[cdb_tag] <= 1'b1;
      if (retire) begin
        busy[head] <= 1'b0;
        done[head] <= 1'b0;
      end
    end
  // payload needs no reset: it is only read once busy/done qualify it
  always_ff @(posedge clock) begin
    if (disp_gnt) begin
      ent[disp_tag].has_rd <= disp_has_rd;
      ent[disp_tag].rd <= disp_rd;
    end
    if (complete) ent[cdb_tag].data <= cdb_data;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      RB_valid_rst <= 1'b0;
      RB_tag_rst <= '0;
      commit_wen <= 1'b0;
      commit_rd <= '0;
      commit_data <= '0;
    end else if (flush) begin
      RB_valid_rst <= 1'b0;
      RB_tag_rst <= '0;
      commit_wen <= 1'b0;
      commit_rd <= '0;
      commit_data <= '0;
    end else begin
      RB_valid_rst <= retire & ent[head].has_rd;
      commit_wen <= retire & ent[head].has_rd;
      if (retire) begin
        RB_tag_rst <= head;
        commit_rd <= ent[head].rd;
        commit_data <= ent[head].data;
      end
    end
endmodule

// File: tb/tb_rob_tag_ctrl.sv
// tb_rob_tag_ctrl: directed vectors plus random traffic against a queue-based ROB model
module tb_rob_tag_ctrl;
  import rob_tag_ctrl_pkg::*;
  logic clock = 0, reset = 1, flush = 0, disp_req = 0, disp_has_rd = 0, cdb_valid = 0;
  logic [AREG_W-1:0] disp_rd = '0;
  logic [TAG_W-1:0] cdb_tag = '0;
  logic [DATA_W-1:0] cdb_data = '0;
  logic disp_gnt, RB_valid_rst, commit_wen, full, empty;
  logic [TAG_W-1:0] disp_tag, RB_tag_rst;
  logic [AREG_W-1:0] commit_rd;
  logic [DATA_W-1:0] commit_data;
  logic [TAG_W:0] count;

  rob_tag_ctrl dut (
    .clock(clock), .reset(reset), .flush(flush), .disp_req(disp_req), .disp_has_rd(disp_has_rd),
    .disp_rd(disp_rd), .disp_gnt(disp_gnt), .disp_tag(disp_tag), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .RB_valid_rst(RB_valid_rst), .RB_tag_rst(RB_tag_rst),
    .commit_wen(commit_wen), .commit_rd(commit_rd), .commit_data(commit_data), .full(full),
    .empty(empty), .count(count)
  );

  always #5 clock = ~clock;

  int passed = 0, total = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    int tag;
    bit has_rd;
    int rd;
    bit dn;
    logic [31:0] data;
  } ment_t;
  ment_t q[$];
  int mtail, e_tag, e_rd;
  bit e_rbv;
  logic [31:0] e_data;
  bit s_gnt;
  int s_tag;

  task automatic model_reset();
    q.delete();
    mtail = 0; e_rbv = 0; e_tag = 0; e_rd = 0; e_data = 0;
  endtask

  task automatic chk_regs();
    chk("RB_valid_rst", RB_valid_rst, e_rbv);
    chk("commit_wen", commit_wen, e_rbv);
    chk("RB_tag_rst", RB_tag_rst, e_tag);
    chk("commit_rd", commit_rd, e_rd);
    chk("commit_data", commit_data, e_data);
    chk("count", count, q.size());
  endtask

  task automatic cyc(input bit rq, input bit hr, input int rd, input bit cv, input int ct,
                     input logic [31:0] cd, input bit fl);
    bit gnt, ret;
    disp_req = rq; disp_has_rd = hr; disp_rd = rd[AREG_W-1:0];
    cdb_valid = cv; cdb_tag = ct[TAG_W-1:0]; cdb_data = cd; flush = fl;
    #1;
    gnt = rq && q.size() < DEPTH && !fl;
    chk("disp_gnt", disp_gnt, gnt);
    chk("disp_tag", disp_tag, mtail);
    chk("full", full, q.size() == DEPTH);
    chk("empty", empty, q.size() == 0);
    s_gnt = disp_gnt;
    s_tag = int'(disp_tag);
    @(posedge clock);
    if (fl) model_reset();
    else begin
      ret = q.size() > 0 && q[0].dn;
      if (cv) foreach (q[i]) if (q[i].tag == ct && !q[i].dn) begin q[i].dn = 1; q[i].data = cd; end
      if (ret) begin
        e_rbv = q[0].has_rd; e_tag = q[0].tag; e_rd = q[0].rd; e_data = q[0].data;
        void'(q.pop_front());
      end else e_rbv = 0;
      if (gnt) begin
        q.push_back('{tag: mtail, has_rd: hr, rd: rd, dn: 0, data: 0});
        mtail = (mtail + 1) % DEPTH;
      end
    end
    #1;
    chk_regs();
    @(negedge clock);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    disp_req = 0; cdb_valid = 0; flush = 0;
    reset = 1;
    #1;
    model_reset();
    chk_regs();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    @(negedge clock);
    reset = 0;
    #1;
  endtask

  typedef struct {
    bit rq, hr; int rd; bit cv; int ct; logic [31:0] cd;
    bit gnt; int tag; bit rbv; int rbtag, crd; logic [31:0] cdat; int cnt;
  } vec_t;
  vec_t tv[7];

  initial begin
    tv[0] = '{1, 1, 3, 0, 0, 32'h0,      1, 0, 0, 0, 0, 32'h0,      1};
    tv[1] = '{1, 1, 7, 0, 0, 32'h0,      1, 1, 0, 0, 0, 32'h0,      2};
    tv[2] = '{0, 0, 0, 1, 1, 32'hBEEF,   0, 2, 0, 0, 0, 32'h0,      2};
    tv[3] = '{0, 0, 0, 1, 0, 32'h1234,   0, 2, 0, 0, 0, 32'h0,      2};
    tv[4] = '{0, 0, 0, 0, 0, 32'h0,      0, 2, 1, 0, 3, 32'h1234,   1};
    tv[5] = '{0, 0, 0, 0, 0, 32'h0,      0, 2, 1, 1, 7, 32'hBEEF,   0};
    tv[6] = '{0, 0, 0, 0, 0, 32'h0,      0, 2, 0, 1, 7, 32'hBEEF,   0};
    @(negedge clock);
    do_reset();
    @(negedge clock);
    foreach (tv[i]) begin
      cyc(tv[i].rq, tv[i].hr, tv[i].rd, tv[i].cv, tv[i].ct, tv[i].cd, 0);
      chk($sformatf("v%0d_gnt", i), s_gnt, tv[i].gnt);
      chk($sformatf("v%0d_tag", i), s_tag, tv[i].tag);
      chk($sformatf("v%0d_rbv", i), RB_valid_rst, tv[i].rbv);
      chk($sformatf("v%0d_wen", i), commit_wen, tv[i].rbv);
      chk($sformatf("v%0d_rbtag", i), RB_tag_rst, tv[i].rbtag);
      chk($sformatf("v%0d_rd", i), commit_rd, tv[i].crd);
      chk($sformatf("v%0d_data", i), commit_data, tv[i].cdat);
      chk($sformatf("v%0d_cnt", i), count, tv[i].cnt);
    end

    // fill to full, blocked grant, retire with a simultaneous request, then wrap
    do_reset();
    @(negedge clock);
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, i, 0, 0, 0, 0);
    chk("full32", full, 1);
    cyc(1, 1, 9, 0, 0, 0, 0);
    chk("gnt33", s_gnt, 0);
    cyc(0, 0, 0, 1, 0, 32'hA0A0, 0);
    cyc(1, 1, 5, 0, 0, 0, 0);
    chk("gnt_full_retire", s_gnt, 0);
    chk("retire_t0", RB_valid_rst, 1);
    cyc(1, 1, 5, 0, 0, 0, 0);
    chk("gnt_wrap", s_gnt, 1);
    chk("tag_wrap", s_tag, 0);

    // entry without destination retires silently
    do_reset();
    @(negedge clock);
    cyc(1, 0, 9, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 32'h55, 0);
    idle();
    chk("nord_rbv", RB_valid_rst, 0);
    chk("nord_wen", commit_wen, 0);
    chk("nord_empty", empty, 1);
    cyc(1, 1, 2, 0, 0, 0, 0);
    chk("nord_next_tag", s_tag, 1);

    // flush with five busy entries
    do_reset();
    @(negedge clock);
    for (int i = 0; i < 5; i++) cyc(1, 1, i + 1, 0, 0, 0, 0);
    cyc(1, 1, 4, 0, 0, 0, 1);
    chk("flush_gnt", s_gnt, 0);
    chk("flush_cnt", count, 0);
    cyc(0, 0, 0, 1, 2, 32'hDEAD, 0);
    idle();
    chk("flush_cdb_ign", RB_valid_rst, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    chk("flush_tag0", s_tag, 0);

    // reset mid-run after a retire left non-zero outputs
    do_reset();
    @(negedge clock);
    for (int i = 0; i < 4; i++) cyc(1, 1, i + 10, 0, 0, 0, 0);
    for (int i = 3; i >= 0; i--) cyc(0, 0, 0, 1, i, 32'h100 + i, 0);
    idle();
    chk("pre_rst_data", commit_data, 32'h100);
    #2;
    do_reset();
    chk("mid_rst_cnt", count, 0);
    for (int i = 0; i < 4; i++) idle();

    // random traffic
    do_reset();
    @(negedge clock);
    for (int n = 0; n < 3000; n++) begin
      int ct;
      ct = (q.size() > 0 && $urandom_range(0, 3) != 0) ? q[$urandom_range(0, q.size() - 1)].tag
                                                        : int'($urandom_range(0, DEPTH - 1));
      cyc($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)),
          $urandom_range(0, 1) == 1, ct, $urandom, $urandom_range(0, 99) == 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
